// File: rtl/cpu_pkg.sv
// Shared CPU pipeline definitions: forward-select encoding, register address
// width and the per-stage destination-register info carried by the shadow pipeline.
package cpu_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned FWD_SEL_W  = 2;

  typedef logic [FWD_SEL_W-1:0]  fwd_sel_t;
  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  localparam fwd_sel_t FWD_RF  = 2'd0;
  localparam fwd_sel_t FWD_EX  = 2'd1;
  localparam fwd_sel_t FWD_MEM = 2'd2;
  localparam fwd_sel_t FWD_WB  = 2'd3;

  typedef struct packed {
    logic      valid;
    reg_addr_t rd;
    logic      we;
    logic      is_load;
  } stage_info_t;

  // True when a stage will write architectural register r (x0 never counts).
  function automatic logic stage_writes(stage_info_t s, reg_addr_t r);
    return s.valid & s.we & (s.rd == r) & (r != '0);
  endfunction

endpackage

// File: rtl/rf_hazard_ctrl_if.sv
// ID-stage hazard/forwarding bundle between the pipeline and rf_hazard_ctrl.
// master: pipeline side (drives ID info and branch resolve, receives controls).
// slave : hazard controller.
interface rf_hazard_ctrl_if #(
  parameter int unsigned CNT_W = 32
);
  import cpu_pkg::*;

  logic       id_valid;
  reg_addr_t  id_rs1;
  reg_addr_t  id_rs2;
  logic       id_use_rs1;
  logic       id_use_rs2;
  reg_addr_t  id_rd;
  logic       id_we;
  logic       id_is_load;
  logic       ex_branch_taken;

  fwd_sel_t   fwd_a_sel;
  fwd_sel_t   fwd_b_sel;
  logic       stall_if;
  logic       bubble_ex;
  logic       flush_ifid;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
           id_rd, id_we, id_is_load, ex_branch_taken,
    input  fwd_a_sel, fwd_b_sel, stall_if, bubble_ex, flush_ifid,
           stall_cnt, flush_cnt
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
           id_rd, id_we, id_is_load, ex_branch_taken,
    output fwd_a_sel, fwd_b_sel, stall_if, bubble_ex, flush_ifid,
           stall_cnt, flush_cnt
  );

endinterface

// File: rtl/rf_fwd_sel.sv
// Per-operand forward-select comparator (purely combinational).
// Ports: src/use_src - ID source register and its read flag;
//        ex_s/mem_s/wb_s - shadow stage info; sel_c - 2-bit operand source.
module rf_fwd_sel
  import cpu_pkg::*;
(
  input  reg_addr_t   src,
  input  logic        use_src,
  input  stage_info_t ex_s,
  input  stage_info_t mem_s,
  input  stage_info_t wb_s,
  output fwd_sel_t    sel_c
);

  // Load flag is irrelevant here: MEM-stage load data forwards like any result.
  logic unused_load;
  assign unused_load = ex_s.is_load ^ mem_s.is_load ^ wb_s.is_load;

  // Youngest producer wins.
  always_comb begin
    sel_c = FWD_RF;
    if (use_src) begin
      if (stage_writes(ex_s, src))       sel_c = FWD_EX;
      else if (stage_writes(mem_s, src)) sel_c = FWD_MEM;
      else if (stage_writes(wb_s, src))  sel_c = FWD_WB;
    end
  end

endmodule

// File: rtl/rf_hazard_ctrl.sv
// Register-file hazard and forwarding controller beside the ID stage.
// Ports: clk, rst (async, active-high); bus (slave) carries ID info and branch
// resolve in, forward selects, IF/ID and ID/EX enables/clears and the
// stall/flush performance counters out.
module rf_hazard_ctrl
  import cpu_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  rf_hazard_ctrl_if.slave    bus
);

  stage_info_t ex_s, mem_s, wb_s;
  stage_info_t ex_n;
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
  logic [CNT_W-1:0] stall_cnt_n, flush_cnt_n;
  logic load_use, stall_if, bubble_ex, flush_ifid;
  fwd_sel_t sel_a, sel_b;

  rf_fwd_sel u_fwd_a (
    .src     (bus.id_rs1),
    .use_src (bus.id_use_rs1),
    .ex_s    (ex_s),
    .mem_s   (mem_s),
    .wb_s    (wb_s),
    .sel_c   (sel_a)
  );

  rf_fwd_sel u_fwd_b (
    .src     (bus.id_rs2),
    .use_src (bus.id_use_rs2),
    .ex_s    (ex_s),
    .mem_s   (mem_s),
    .wb_s    (wb_s),
    .sel_c   (sel_b)
  );

  // Shadow pipeline and counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_s        <= '0;
      mem_s       <= '0;
      wb_s        <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      ex_s        <= ex_n;
      mem_s       <= ex_s;
      wb_s        <= mem_s;
      stall_cnt_q <= stall_cnt_n;
      flush_cnt_q <= flush_cnt_n;
    end
  end

  // Hazard detection, pipeline controls and next-state.
  always_comb begin
    load_use    = 1'b0;
    stall_if    = 1'b0;
    bubble_ex   = 1'b0;
    flush_ifid  = 1'b0;
    ex_n        = '0;
    stall_cnt_n = stall_cnt_q;
    flush_cnt_n = flush_cnt_q;

    load_use = bus.id_valid & ex_s.valid & ex_s.is_load & ex_s.we &
               (ex_s.rd != '0) &
               ((bus.id_use_rs1 & (bus.id_rs1 == ex_s.rd)) |
                (bus.id_use_rs2 & (bus.id_rs2 == ex_s.rd)));

    // A taken branch overrides the stall: the PC must follow the redirect.
    flush_ifid = bus.ex_branch_taken;
    stall_if   = load_use & ~bus.ex_branch_taken;
    bubble_ex  = load_use | bus.ex_branch_taken;

    ex_n.valid   = bus.id_valid & ~bubble_ex;
    ex_n.rd      = bus.id_rd;
    ex_n.we      = bus.id_we;
    ex_n.is_load = bus.id_is_load;

    if (stall_if)   stall_cnt_n = stall_cnt_q + CNT_W'(1);
    if (flush_ifid) flush_cnt_n = flush_cnt_q + CNT_W'(1);
  end

  assign bus.fwd_a_sel  = sel_a;
  assign bus.fwd_b_sel  = sel_b;
  assign bus.stall_if   = stall_if;
  assign bus.bubble_ex  = bubble_ex;
  assign bus.flush_ifid = flush_ifid;
  assign bus.stall_cnt  = stall_cnt_q;
  assign bus.flush_cnt  = flush_cnt_q;

endmodule
